// File: rtl/rtc_display_overlay_regs.sv
// PicoBlaze display register file plus pixel overlay (cursor highlight, key flash, optional blink).
// Registered pixel path, 1-cycle latency, no backpressure; optional blink built with RTC_OVERLAY_BLINK_EN.
module rtc_display_overlay_regs #(
  parameter int                 NUM_FIELDS   = 9,
  parameter logic [7:0]         FIELD_BASE   = 8'h02,
  parameter logic [7:0]         PTR_PORT     = 8'h0E,
  parameter logic [7:0]         CTRL_PORT    = 8'h0F,
  parameter int                 COLOR_W      = 12,
  parameter logic [COLOR_W-1:0] HILITE_COLOR = 'hF00,
  parameter int                 FLASH_FRAMES = 8,
  parameter int                 BLINK_FRAMES = 30
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    WRITE_STROBE,
  input  logic [7:0]              PORT_ID,
  input  logic [7:0]              OUT_PORT,
  input  logic                    KEY_VALID,
  input  logic [7:0]              KEY_CODE,
  input  logic                    VS,
  input  logic [COLOR_W-1:0]      PIX_COLOR,
  input  logic [3:0]              PIX_FIELD,
  input  logic [2:0]              PIX_KEYZONE,
  output logic [8*NUM_FIELDS-1:0] FIELD_BUS,
  output logic [7:0]              POINTER,
  output logic [COLOR_W-1:0]      RGB
);

  typedef enum logic {K_IDLE, K_BREAK} key_state_t;

  logic [7:0] field_q [NUM_FIELDS];
  logic [7:0] pointer_q;
  logic       overlay_en_q;
  logic       vs_q;
  logic       frame_tick;
  logic       blink_on;

  key_state_t key_state;
  logic [2:0] flash_zone;
  logic [7:0] flash_timer;
  logic       make_vld;
  logic [2:0] make_zone;

  logic       ptr_ok;
  logic       hilite;
  logic       flash;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NUM_FIELDS; i++) field_q[i] <= 8'h00;
      pointer_q    <= 8'h00;
      overlay_en_q <= 1'b1;
    end else if (WRITE_STROBE) begin
      for (int i = 0; i < NUM_FIELDS; i++)
        if (PORT_ID == FIELD_BASE + 8'(i)) field_q[i] <= OUT_PORT;
      if (PORT_ID == PTR_PORT)  pointer_q    <= OUT_PORT;
      if (PORT_ID == CTRL_PORT) overlay_en_q <= OUT_PORT[0];
    end
  end

  for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_field_bus
    assign FIELD_BUS[8*g +: 8] = field_q[g];
  end
  assign POINTER = pointer_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) vs_q <= 1'b1;
    else      vs_q <= VS;
  end
  assign frame_tick = vs_q & ~VS;

  always_comb begin
    make_vld  = 1'b0;
    make_zone = 3'd0;
    if (KEY_VALID && key_state == K_IDLE) begin
      case (KEY_CODE)
        8'h75:   begin make_vld = 1'b1; make_zone = 3'd1; end
        8'h72:   begin make_vld = 1'b1; make_zone = 3'd2; end
        8'h74:   begin make_vld = 1'b1; make_zone = 3'd3; end
        8'h6B:   begin make_vld = 1'b1; make_zone = 3'd4; end
        default: begin make_vld = 1'b0; make_zone = 3'd0; end
      endcase
    end
  end

  // A reload on the same cycle as a frame tick wins over the decrement.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      key_state   <= K_IDLE;
      flash_zone  <= 3'd0;
      flash_timer <= 8'd0;
    end else begin
      if (KEY_VALID) begin
        case (key_state)
          K_IDLE:  if (KEY_CODE == 8'hF0) key_state <= K_BREAK;
          K_BREAK: key_state <= K_IDLE;
          default: key_state <= K_IDLE;
        endcase
      end
      if (make_vld) begin
        flash_zone  <= make_zone;
        flash_timer <= 8'(FLASH_FRAMES);
      end else if (frame_tick && flash_timer != 8'd0) begin
        flash_timer <= flash_timer - 8'd1;
      end
    end
  end

`ifdef RTC_OVERLAY_BLINK_EN
  localparam int BCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BCW-1:0] blink_cnt;
  logic           blink_en_q;
  logic           blink_phase;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      blink_en_q  <= 1'b0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      if (WRITE_STROBE && PORT_ID == CTRL_PORT) blink_en_q <= OUT_PORT[1];
      if (!blink_en_q) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b1;
      end else if (frame_tick) begin
        if (blink_cnt == BCW'(BLINK_FRAMES - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end
  assign blink_on = blink_phase;
`else
  assign blink_on = 1'b1;
`endif

  assign ptr_ok = (pointer_q != 8'd0) && (pointer_q <= 8'(NUM_FIELDS));
  assign hilite = overlay_en_q && ptr_ok && ({4'd0, PIX_FIELD} == pointer_q) &&
                  (|PIX_COLOR) && blink_on;
  assign flash  = (flash_timer != 8'd0) && (PIX_KEYZONE == flash_zone) && (&PIX_COLOR);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                 RGB <= '0;
    else if (flash || hilite) RGB <= HILITE_COLOR;
    else                      RGB <= PIX_COLOR;
  end

endmodule

// File: tb/tb_rtc_display_overlay_regs.sv
// Directed bench for rtc_display_overlay_regs; pixel results checked by a queue-based scoreboard.
module tb_rtc_display_overlay_regs;

  localparam int NF = 9;
`ifdef RTC_OVERLAY_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic           WRITE_STROBE = 1'b0;
  logic [7:0]     PORT_ID = 8'h00;
  logic [7:0]     OUT_PORT = 8'h00;
  logic           KEY_VALID = 1'b0;
  logic [7:0]     KEY_CODE = 8'h00;
  logic           VS = 1'b1;
  logic [11:0]    PIX_COLOR = 12'h000;
  logic [3:0]     PIX_FIELD = 4'd0;
  logic [2:0]     PIX_KEYZONE = 3'd0;
  logic [8*NF-1:0] FIELD_BUS;
  logic [7:0]     POINTER;
  logic [11:0]    RGB;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q [$];
  string       name_q [$];
  logic        pix_vld = 1'b0;

  rtc_display_overlay_regs #(.NUM_FIELDS(NF), .BLINK_FRAMES(2)) dut (
    .CLK(CLK), .RST(RST), .WRITE_STROBE(WRITE_STROBE), .PORT_ID(PORT_ID),
    .OUT_PORT(OUT_PORT), .KEY_VALID(KEY_VALID), .KEY_CODE(KEY_CODE), .VS(VS),
    .PIX_COLOR(PIX_COLOR), .PIX_FIELD(PIX_FIELD), .PIX_KEYZONE(PIX_KEYZONE),
    .FIELD_BUS(FIELD_BUS), .POINTER(POINTER), .RGB(RGB)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [8*NF-1:0] act, input logic [8*NF-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: every cycle a pixel was presented, RGB one edge later must match the queued value.
  always @(posedge CLK) begin
    if (pix_vld) begin
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rgb_unexpected got %h want <none>", RGB);
      end else begin
        logic [11:0] e;
        string       n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (RGB !== e) begin
          errors++;
          $display("FAIL %s got %h want %h", n, RGB, e);
        end
      end
    end
  end

  task automatic wr(input logic [7:0] p, input logic [7:0] d);
    @(negedge CLK);
    WRITE_STROBE = 1'b1; PORT_ID = p; OUT_PORT = d;
    @(negedge CLK);
    WRITE_STROBE = 1'b0; PORT_ID = 8'h00; OUT_PORT = 8'h00;
  endtask

  task automatic key(input logic [7:0] c);
    @(negedge CLK);
    KEY_VALID = 1'b1; KEY_CODE = c;
    @(negedge CLK);
    KEY_VALID = 1'b0; KEY_CODE = 8'h00;
  endtask

  task automatic tick();
    @(negedge CLK); VS = 1'b0;
    @(negedge CLK); VS = 1'b1;
  endtask

  task automatic key_tick(input logic [7:0] c);
    @(negedge CLK);
    KEY_VALID = 1'b1; KEY_CODE = c; VS = 1'b0;
    @(negedge CLK);
    KEY_VALID = 1'b0; KEY_CODE = 8'h00; VS = 1'b1;
  endtask

  task automatic pix(input string nm, input logic [11:0] c, input logic [3:0] f,
                     input logic [2:0] z, input logic [11:0] e);
    @(negedge CLK);
    PIX_COLOR = c; PIX_FIELD = f; PIX_KEYZONE = z; pix_vld = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge CLK);
    pix_vld = 1'b0; PIX_COLOR = 12'h000; PIX_FIELD = 4'd0; PIX_KEYZONE = 3'd0;
  endtask

  initial begin
    logic [11:0] blink_exp [5];
    blink_exp = '{12'hF00, 12'hF00, 12'hFFF, 12'hFFF, 12'hF00};

    repeat (3) @(negedge CLK);
    chk("rgb_in_reset", {60'd0, RGB}, '0);
    RST = 1'b1;
    @(negedge CLK);
    chk("fields_reset", FIELD_BUS, '0);
    chk("pointer_reset", {64'd0, POINTER}, '0);
    chk("rgb_reset", {60'd0, RGB}, '0);

    wr(8'h05, 8'h59);
    chk("field3_write", FIELD_BUS, {{(8*NF-32){1'b0}}, 32'h5900_0000});
    wr(8'h20, 8'hFF);
    chk("unmatched_port", FIELD_BUS, {{(8*NF-32){1'b0}}, 32'h5900_0000});

    wr(8'h0E, 8'h02);
    chk("pointer_write", {64'd0, POINTER}, {64'd0, 8'h02});
    pix("hilite_on", 12'hFFF, 4'd2, 3'd0, 12'hF00);
    pix("hilite_black", 12'h000, 4'd2, 3'd0, 12'h000);
    pix("hilite_other_field", 12'hFFF, 4'd3, 3'd0, 12'hFFF);

    wr(8'h0F, 8'h00);
    pix("overlay_disabled", 12'hFFF, 4'd2, 3'd0, 12'hFFF);
    wr(8'h0F, 8'h01);

    wr(8'h0E, 8'h00);
    pix("ptr_zero", 12'hFFF, 4'd0, 3'd0, 12'hFFF);
    wr(8'h0E, 8'h0A);
    pix("ptr_over_range", 12'hFFF, 4'd10, 3'd0, 12'hFFF);
    wr(8'h0E, 8'h09);
    pix("ptr_max", 12'h123, 4'd9, 3'd0, 12'hF00);

    key(8'h75);
    pix("flash_up", 12'hFFF, 4'd0, 3'd1, 12'hF00);
    pix("flash_not_white", 12'hABC, 4'd0, 3'd1, 12'hABC);
    pix("flash_wrong_zone", 12'hFFF, 4'd0, 3'd2, 12'hFFF);
    for (int i = 1; i <= 8; i++) begin
      tick();
      pix($sformatf("flash_frame%0d", i), 12'hFFF, 4'd0, 3'd1, (i < 8) ? 12'hF00 : 12'hFFF);
    end

    key(8'hF0);
    key(8'h75);
    pix("break_no_flash", 12'hFFF, 4'd0, 3'd1, 12'hFFF);

    key(8'h75);
    tick();
    tick();
    key_tick(8'h72);
    pix("reload_zone2", 12'hFFF, 4'd0, 3'd2, 12'hF00);
    pix("reload_zone1_pass", 12'hFFF, 4'd0, 3'd1, 12'hFFF);
    repeat (7) tick();
    pix("reload_held_8", 12'hFFF, 4'd0, 3'd2, 12'hF00);
    tick();
    pix("reload_expired", 12'hFFF, 4'd0, 3'd2, 12'hFFF);

    wr(8'h0E, 8'h02);
    wr(8'h0F, 8'h03);
    for (int i = 0; i < 5; i++) begin
      pix($sformatf("blink_frame%0d", i), 12'hFFF, 4'd2, 3'd0, BLINK_EN ? blink_exp[i] : 12'hF00);
      if (i < 4) tick();
    end
    wr(8'h0F, 8'h01);

    wr(8'h0E, 8'h05);
    key(8'h75);
    @(negedge CLK);
    PIX_COLOR = 12'hFFF; PIX_FIELD = 4'd5; PIX_KEYZONE = 3'd1;
    @(posedge CLK);
    #1 chk("pre_reset_flash", {60'd0, RGB}, {60'd0, 12'hF00});
    #2 RST = 1'b0;
    #1 chk("async_reset_rgb", {60'd0, RGB}, '0);
    @(negedge CLK);
    chk("reset_held_rgb", {60'd0, RGB}, '0);
    RST = 1'b1;
    PIX_COLOR = 12'h000; PIX_FIELD = 4'd0; PIX_KEYZONE = 3'd0;
    @(negedge CLK);
    chk("post_reset_fields", FIELD_BUS, '0);
    chk("post_reset_pointer", {64'd0, POINTER}, '0);
    pix("post_reset_no_flash", 12'hFFF, 4'd0, 3'd1, 12'hFFF);
    pix("post_reset_no_hilite", 12'hFFF, 4'd5, 3'd1, 12'hFFF);

    repeat (3) @(negedge CLK);
    chk("scoreboard_drained", {40'd0, 32'(exp_q.size())}, '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
